// File: rtl/snake_matrix_scan_pkg.sv
// Shared constants and build-state encoding for the snake display path.
// Grid geometry matches the game core: idx = GRID_W*R + C.
package snake_pkg;
  localparam int GRID_W   = 10;
  localparam int CELL_MIN = 12;
  localparam int CELL_MAX = 89;
  localparam int COL_MIN  = 2;
  localparam int SEG_W    = 8;
  localparam int N_SEG    = 9;

  typedef enum logic [1:0] {LOAD, BUILD, WAIT} build_state_t;
endpackage

// File: rtl/snake_matrix_scan_if.sv
// Game-state inputs and LED matrix drive of the snake display stage.
interface snake_matrix_scan_if;
  import snake_pkg::*;

  logic [SEG_W*N_SEG-1:0] snake;
  logic [SEG_W-1:0]       apple;
  logic [7:0]             row_sel;
  logic [7:0]             col_on;
  logic                   frame_tick;

  modport master (output snake, apple, input row_sel, col_on, frame_tick);
  modport slave  (input snake, apple, output row_sel, col_on, frame_tick);
endinterface

// File: rtl/snake_matrix_scan_cell_decode.sv
// Maps a playfield cell index to an 8x8 matrix position; wall and empty
// cells (including 0) come back invalid.
module cell_decode
  import snake_pkg::*;
(
  input  logic [SEG_W-1:0] idx,
  output logic             valid,
  output logic [2:0]       row,
  output logic [2:0]       col
);
  logic [SEG_W-1:0] r_full;
  logic [SEG_W-1:0] c_full;

  always_comb begin
    r_full = idx / SEG_W'(GRID_W);
    c_full = idx % SEG_W'(GRID_W);
    valid  = (idx >= SEG_W'(CELL_MIN)) && (idx <= SEG_W'(CELL_MAX)) &&
             (c_full >= SEG_W'(COL_MIN));
    row    = 3'(r_full - SEG_W'(1));
    col    = 3'(c_full - SEG_W'(COL_MIN));
  end
endmodule

// File: rtl/snake_matrix_scan.sv
// Renders snake body and apple into a double-buffered 8x8 bitmap and scans
// it out row by row; the apple blinks every BLINK_FRAMES frames.
//
//   state | meaning
//   LOAD  | snapshot inputs, clear shadow bitmaps
//   BUILD | decode one cell per cycle (k=0..8 body, k=9 apple)
//   WAIT  | hold shadow until the next frame wrap, then swap
module snake_matrix_scan
  import snake_pkg::*;
#(
  parameter int DWELL        = 1000,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                clk,
  input  logic                rst,
  snake_matrix_scan_if.slave  bus
);
  localparam int DWELL_W = $clog2(DWELL);
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DWELL_W-1:0]     dwell_cnt;
  logic [2:0]             row_ptr;
  logic [BLINK_W-1:0]     blink_cnt;
  logic                   blink_on;
  logic                   row_end;
  logic                   wrap;

  build_state_t           state;
  logic [3:0]             k;
  logic [SEG_W*N_SEG-1:0] snake_snap;
  logic [SEG_W-1:0]       apple_snap;
  logic [7:0][7:0]        body_shadow, apple_shadow;
  logic [7:0][7:0]        body_disp, apple_disp;
  logic                   disp_valid;

  logic [SEG_W-1:0]       dec_idx;
  logic                   dec_valid;
  logic [2:0]             dec_row, dec_col;

  assign row_end = (dwell_cnt == DWELL_W'(DWELL - 1));
  assign wrap    = row_end && (row_ptr == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst) begin
      dwell_cnt      <= '0;
      row_ptr        <= '0;
      blink_cnt      <= '0;
      blink_on       <= 1'b1;
      bus.row_sel    <= '0;
      bus.col_on     <= '0;
      bus.frame_tick <= 1'b0;
    end else begin
      if (row_end) begin
        dwell_cnt <= '0;
        row_ptr   <= row_ptr + 3'd1;
      end else begin
        dwell_cnt <= dwell_cnt + DWELL_W'(1);
      end
      bus.frame_tick <= wrap;
      // rows stay deselected until the first image has been swapped in
      bus.row_sel    <= disp_valid ? (8'd1 << row_ptr) : 8'd0;
      bus.col_on     <= body_disp[row_ptr] |
                        (blink_on ? apple_disp[row_ptr] : 8'd0);
      if (BLINK_FRAMES == 0) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (wrap) begin
        if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + BLINK_W'(1);
        end
      end
    end
  end

  always_comb begin
    dec_idx = apple_snap;
    if (k < 4'(N_SEG)) dec_idx = snake_snap[k*SEG_W +: SEG_W];
  end

  cell_decode u_dec (
    .idx   (dec_idx),
    .valid (dec_valid),
    .row   (dec_row),
    .col   (dec_col)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= LOAD;
      k            <= '0;
      snake_snap   <= '0;
      apple_snap   <= '0;
      body_shadow  <= '0;
      apple_shadow <= '0;
      body_disp    <= '0;
      apple_disp   <= '0;
      disp_valid   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          snake_snap   <= bus.snake;
          apple_snap   <= bus.apple;
          body_shadow  <= '0;
          apple_shadow <= '0;
          k            <= '0;
          state        <= BUILD;
        end
        BUILD: begin
          if (dec_valid) begin
            if (k == 4'(N_SEG)) apple_shadow[dec_row][dec_col] <= 1'b1;
            else                body_shadow[dec_row][dec_col]  <= 1'b1;
          end
          if (k == 4'(N_SEG)) state <= WAIT;
          else                k     <= k + 4'd1;
        end
        WAIT: begin
          // swap on the same edge that wraps the scan, so row 0 is never stale
          if (wrap) begin
            body_disp  <= body_shadow;
            apple_disp <= apple_shadow;
            disp_valid <= 1'b1;
            state      <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_snake_matrix_scan.sv
// Bench for snake_matrix_scan: frame-level reference model checked every
// cycle on a blinking and a steady-apple instance, plus directed sequences.
module tb_snake_matrix_scan;
  import snake_pkg::*;

  localparam int DW = 4;
  localparam int FR = 8 * DW;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [71:0] snake_v = '0;
  logic [7:0]  apple_v = '0;

  snake_matrix_scan_if bus_b ();
  snake_matrix_scan_if bus_s ();

  assign bus_b.snake = snake_v;
  assign bus_b.apple = apple_v;
  assign bus_s.snake = snake_v;
  assign bus_s.apple = apple_v;

  snake_matrix_scan #(.DWELL(DW), .BLINK_FRAMES(BF)) dut (
    .clk (clk), .rst (rst), .bus (bus_b.slave)
  );
  snake_matrix_scan #(.DWELL(DW), .BLINK_FRAMES(0)) dut_s (
    .clk (clk), .rst (rst), .bus (bus_s.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int t = 0;
  logic [63:0] body_q[$];
  logic [63:0] apple_q[$];

  typedef struct {
    string       name;
    logic [71:0] snake;
    logic [7:0]  apple;
    logic [63:0] frame;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [71:0] seg(input int k, input logic [7:0] v);
    seg = 72'(v) << (8 * k);
  endfunction

  function automatic logic [63:0] cell_bit(input logic [7:0] idx);
    int r, c;
    cell_bit = '0;
    r = int'(idx) / 10;
    c = int'(idx) % 10;
    if (idx >= 12 && idx <= 89 && c >= 2) cell_bit[(r - 1) * 8 + (c - 2)] = 1'b1;
  endfunction

  function automatic logic [63:0] body_img(input logic [71:0] s);
    body_img = '0;
    for (int k = 0; k < 9; k++) body_img |= cell_bit(s[k*8 +: 8]);
  endfunction

  // Frame w (after the w-th wrap) shows the inputs captured right after wrap w-1.
  function automatic logic [16:0] model(input int bf);
    int w, r;
    logic [7:0] rs, co;
    logic [63:0] b, a;
    logic ft, blink;
    ft = (t > 0) && (t % FR == 0);
    rs = '0;
    co = '0;
    if (t > 0) begin
      w = (t - 1) / FR;
      if (w > 0 && w <= body_q.size()) begin
        r     = ((t - 1) / DW) % 8;
        b     = body_q[w-1];
        a     = apple_q[w-1];
        blink = (bf == 0) || ((w / bf) % 2 == 0);
        rs    = 8'(1 << r);
        co    = b[r*8 +: 8] | (blink ? a[r*8 +: 8] : 8'h00);
      end
    end
    return {rs, co, ft};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d: got %h, want %h", name, t, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      t = 0;
      body_q.delete();
      apple_q.delete();
    end else begin
      t++;
      if (t % FR == 1) begin
        body_q.push_back(body_img(snake_v));
        apple_q.push_back(cell_bit(apple_v));
      end
    end
    @(negedge clk);
    check("model_blink",  64'({bus_b.row_sel, bus_b.col_on, bus_b.frame_tick}), 64'(model(BF)));
    check("model_steady", 64'({bus_s.row_sel, bus_s.col_on, bus_s.frame_tick}), 64'(model(0)));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  initial begin
    logic [63:0] frame;
    logic [7:0]  exp_bl[5];

    vecs[0] = '{"head12_apple89", seg(8, 12), 8'd89, 64'h80_00_00_00_00_00_00_01};
    vecs[1] = '{"invalid_cells", seg(0, 10) | seg(1, 21) | seg(2, 90) | seg(8, 45),
                8'd0, 64'h00_00_00_00_08_00_00_00};
    vecs[2] = '{"overlap", seg(8, 45), 8'd45, 64'h00_00_00_00_08_00_00_00};
    vecs[3] = '{"apple_only", '0, 8'd34, 64'h00_00_00_00_00_04_00_00};
    vecs[4] = '{"corners", seg(0, 19) | seg(1, 82) | seg(8, 55), 8'd11,
                64'h01_00_00_08_00_00_00_80};

    // Reset and first frame
    snake_v = seg(8, 12);
    apple_v = 8'd89;
    do_reset();
    repeat (64) begin
      tick();
      if (t == 32) check("first_tick", 64'(bus_s.frame_tick), 64'd1);
      if (t == 33) check("row0_first", 64'({bus_s.row_sel, bus_s.col_on}), 64'h0101);
      if (t == 61) check("row7_first", 64'({bus_s.row_sel, bus_s.col_on}), 64'h8080);
    end

    // Table of images, read back from the steady-apple instance
    for (int i = 0; i < 5; i++) begin
      snake_v = vecs[i].snake;
      apple_v = vecs[i].apple;
      repeat (2 * FR + 2) tick();
      frame = '0;
      repeat (FR) begin
        tick();
        for (int r = 0; r < 8; r++)
          if (bus_s.row_sel == 8'(1 << r)) frame[r*8 +: 8] = bus_s.col_on;
      end
      check(vecs[i].name, frame, vecs[i].frame);
    end

    // Input change two cycles after LOAD must not reach the current build
    snake_v = seg(8, 12);
    apple_v = 8'd0;
    repeat (2 * FR) tick();
    for (int n = 0; n < FR && t % FR != 3; n++) tick();
    snake_v = seg(8, 13);
    for (int n = 0; n < FR && t % FR != 1; n++) tick();
    check("midbuild_old", 64'({bus_s.row_sel, bus_s.col_on}), 64'h0101);
    repeat (FR) tick();
    check("midbuild_new", 64'({bus_s.row_sel, bus_s.col_on}), 64'h0102);

    // Blink phases on row 2
    exp_bl = '{8'h04, 8'h00, 8'h00, 8'h04, 8'h04};
    snake_v = '0;
    apple_v = 8'd34;
    do_reset();
    repeat (6 * FR) begin
      tick();
      for (int w = 1; w <= 5; w++)
        if (t == FR * w + 10) check($sformatf("blink_w%0d", w), 64'(bus_b.col_on), 64'(exp_bl[w-1]));
    end

    // Body masks apple blink
    snake_v = seg(8, 45);
    apple_v = 8'd45;
    do_reset();
    repeat (4 * FR) begin
      tick();
      for (int w = 1; w <= 3; w++)
        if (t == FR * w + 14) check($sformatf("overlap_w%0d", w), 64'(bus_b.col_on), 64'h08);
    end

    // Reset in the middle of the scan
    for (int n = 0; n < FR && ((t / DW) % 8) != 5; n++) tick();
    rst = 1'b0;
    tick();
    check("rst_row_sel", 64'(bus_b.row_sel), 64'd0);
    check("rst_col_on",  64'(bus_b.col_on),  64'd0);
    rst = 1'b1;
    repeat (40) begin
      tick();
      if (t == 33) check("restart_row0", 64'(bus_b.row_sel), 64'h01);
    end

    // Random inputs, occasional reset (including mid-build)
    for (int e = 0; e < 24; e++) begin
      for (int k = 0; k < 9; k++) snake_v[k*8 +: 8] = 8'($urandom_range(0, 99));
      apple_v = 8'($urandom_range(0, 99));
      if ($urandom_range(0, 5) == 0) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end
      repeat ($urandom_range(1, 70)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
